// File: rtl/pipeline_stall_controller_if.sv
// rtl/pipeline_stall_controller_if.sv - hazard/control bundle between pipeline and stall controller
//
// Purpose: groups the hazard inputs, pipeline control outputs, status and
// performance counters of pipeline_stall_controller into one bundle.
// Signals:
//   StallReq, BranchTaken, JumpTaken, MemBusy      hazard/redirect inputs (driven by master)
//   PCWrite, IFIDWrite, IFIDFlush, IDEXBubble,
//   PipeHold                                       pipeline controls (driven by slave)
//   State[1:0], StallTimeout                       status (driven by slave)
//   StallCycles[15:0], FlushCount[15:0]            performance counters (driven by slave)
// Modports: master = pipeline/hazard side, slave = stall controller.

interface pipeline_stall_controller_if;
  logic        StallReq;
  logic        BranchTaken;
  logic        JumpTaken;
  logic        MemBusy;

  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        IDEXBubble;
  logic        PipeHold;
  logic [1:0]  State;
  logic        StallTimeout;
  logic [15:0] StallCycles;
  logic [15:0] FlushCount;

  modport master (
    output StallReq, BranchTaken, JumpTaken, MemBusy,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeHold,
    input  State, StallTimeout, StallCycles, FlushCount
  );

  modport slave (
    input  StallReq, BranchTaken, JumpTaken, MemBusy,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeHold,
    output State, StallTimeout, StallCycles, FlushCount
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - pipeline stall / flush / freeze controller
//
// Purpose: decides every cycle whether the in-order pipeline runs, inserts a
// hazard bubble, flushes IF/ID after a taken branch/jump, or freezes entirely
// while data memory is busy. Control outputs are combinational from the
// current inputs and the registered state (priority Rst > MemBusy > StallReq
// > flush > normal).
// Ports:
//   Clk            sole clock, rising edge
//   Rst            synchronous, active-high reset
//   bus (slave)    StallReq/BranchTaken/JumpTaken/MemBusy in;
//                  PCWrite/IFIDWrite/IFIDFlush/IDEXBubble/PipeHold,
//                  State (00 RUN, 01 STALL, 10 MEMWAIT), StallTimeout,
//                  StallCycles/FlushCount out
// Parameter:
//   MAX_STALL      consecutive hazard-stall cycles that raise StallTimeout (2..7)
// Configuration macro:
//   STALL_COUNTERS_EN  when defined, StallCycles/FlushCount count saturating
//                      at 16'hFFFF; when undefined they read constant 0.

module pipeline_stall_controller #(
  parameter int MAX_STALL = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  pipeline_stall_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    STALL   = 2'b01,
    MEMWAIT = 2'b10
  } stateT;

  localparam logic [2:0] STALL_LIMIT = 3'(MAX_STALL - 1);

  stateT      state, stateNext;
  logic       pendingFlush, pendingFlushNext;
  logic [2:0] stallRun, stallRunNext;
  logic       stallTimeout, stallTimeoutNext;

  logic       anyRedirect;
  logic       hazardCycle;
  logic       flushCycle;

  logic       pcWrite;
  logic       ifidWrite;
  logic       ifidFlush;
  logic       idexBubble;
  logic       pipeHold;

  // State register and sticky bookkeeping
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= RUN;
      pendingFlush <= 1'b0;
      stallRun     <= 3'd0;
      stallTimeout <= 1'b0;
    end else begin
      state        <= stateNext;
      pendingFlush <= pendingFlushNext;
      stallRun     <= stallRunNext;
      stallTimeout <= stallTimeoutNext;
    end
  end

  // Next-state and pipeline control decode
  always_comb begin
    anyRedirect      = bus.BranchTaken | bus.JumpTaken;
    hazardCycle      = 1'b0;
    flushCycle       = 1'b0;

    pcWrite          = 1'b1;
    ifidWrite        = 1'b1;
    ifidFlush        = 1'b0;
    idexBubble       = 1'b0;
    pipeHold         = 1'b0;

    stateNext        = RUN;
    pendingFlushNext = pendingFlush;
    stallRunNext     = 3'd0;
    stallTimeoutNext = stallTimeout;

    if (Rst) begin
      // Reset drains the front end: IF/ID to NOP and a bubble into ID/EX.
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (bus.MemBusy) begin
      // Whole pipeline frozen. A redirect seen now cannot be applied yet
      // (IF/ID is frozen too), so remember it for the first free cycle.
      pcWrite      = 1'b0;
      ifidWrite    = 1'b0;
      pipeHold     = 1'b1;
      stateNext    = MEMWAIT;
      stallRunNext = stallRun;
      if (anyRedirect) begin
        pendingFlushNext = 1'b1;
      end
    end else if (bus.StallReq) begin
      // Operands of the branch are not ready, so BranchTaken/JumpTaken are
      // not trustworthy this cycle and are deliberately ignored.
      hazardCycle  = 1'b1;
      pcWrite      = 1'b0;
      ifidWrite    = 1'b0;
      idexBubble   = 1'b1;
      stateNext    = STALL;
      // Saturate so a very long stall never wraps back into the window.
      stallRunNext = (stallRun == 3'd7) ? stallRun : stallRun + 3'd1;
      if (stallRun == STALL_LIMIT) begin
        stallTimeoutNext = 1'b1;
      end
    end else if (anyRedirect || pendingFlush) begin
      // Branch and jump together still cost exactly one flush.
      flushCycle = 1'b1;
      ifidFlush  = 1'b1;
    end

    if (flushCycle) begin
      pendingFlushNext = 1'b0;
    end
  end

  assign bus.PCWrite      = pcWrite;
  assign bus.IFIDWrite    = ifidWrite;
  assign bus.IFIDFlush    = ifidFlush;
  assign bus.IDEXBubble   = idexBubble;
  assign bus.PipeHold     = pipeHold;
  assign bus.State        = state;
  assign bus.StallTimeout = stallTimeout;

`ifdef STALL_COUNTERS_EN
  logic [15:0] stallCycles;
  logic [15:0] flushCount;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stallCycles <= 16'd0;
      flushCount  <= 16'd0;
    end else begin
      if (hazardCycle && (stallCycles != 16'hFFFF)) begin
        stallCycles <= stallCycles + 16'd1;
      end
      if (flushCycle && (flushCount != 16'hFFFF)) begin
        flushCount <= flushCount + 16'd1;
      end
    end
  end

  assign bus.StallCycles = stallCycles;
  assign bus.FlushCount  = flushCount;
`else
  assign bus.StallCycles = 16'd0;
  assign bus.FlushCount  = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - scoreboard bench for pipeline_stall_controller

module tb_pipeline_stall_controller;

  localparam int MAX_STALL = 4;
  localparam int SAT       = 65535;

  logic clk;
  logic rst;

  pipeline_stall_controller_if bus ();

  pipeline_stall_controller #(.MAX_STALL(MAX_STALL)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       pc;
    bit       ifid;
    bit       flush;
    bit       bubble;
    bit       hold;
    bit [1:0] st;
    bit       tmo;
    int       sc;
    int       fc;
  } expT;

  expT q[$];

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: architectural view of the controller
  int mState;       // 0 run, 1 stall, 2 memwait
  bit mPending;     // redirect owed from a frozen cycle
  int mRunLen;      // consecutive hazard stalls (frozen cycles do not break a run)
  bit mTimeout;
  int mStalls;
  int mFlushes;

  function automatic void modelReset();
    mState   = 0;
    mPending = 0;
    mRunLen  = 0;
    mTimeout = 0;
    mStalls  = 0;
    mFlushes = 0;
  endfunction

  function automatic int satInc(int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic chk(string name, int act, int req);
    testsRun++;
    if (act != req) begin
      testsFailed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs, predict that cycle's observable values, then
  // advance the model across the following clock edge.
  task automatic drive(input bit r, input bit s, input bit b, input bit j, input bit m);
    expT e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.StallReq    = s;
    bus.BranchTaken = b;
    bus.JumpTaken   = j;
    bus.MemBusy     = m;

    e.st  = 2'(mState);
    e.tmo = mTimeout;
`ifdef STALL_COUNTERS_EN
    e.sc = mStalls;
    e.fc = mFlushes;
`else
    e.sc = 0;
    e.fc = 0;
`endif

    if (r) begin
      e.pc = 0; e.ifid = 0; e.flush = 1; e.bubble = 1; e.hold = 0;
      modelReset();
    end else if (m) begin
      e.pc = 0; e.ifid = 0; e.flush = 0; e.bubble = 0; e.hold = 1;
      mState = 2;
      if (b || j) mPending = 1;
    end else if (s) begin
      e.pc = 0; e.ifid = 0; e.flush = 0; e.bubble = 1; e.hold = 0;
      mState  = 1;
      mRunLen = mRunLen + 1;
      if (mRunLen >= MAX_STALL) mTimeout = 1;
      mStalls = satInc(mStalls);
    end else if (b || j || mPending) begin
      e.pc = 1; e.ifid = 1; e.flush = 1; e.bubble = 0; e.hold = 0;
      mState   = 0;
      mPending = 0;
      mRunLen  = 0;
      mFlushes = satInc(mFlushes);
    end else begin
      e.pc = 1; e.ifid = 1; e.flush = 0; e.bubble = 0; e.hold = 0;
      mState  = 0;
      mRunLen = 0;
    end
    q.push_back(e);
  endtask

  // Monitor: outputs are stable mid-cycle, compare against the oldest prediction
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PCWrite",      int'(bus.PCWrite),      int'(e.pc));
        chk("IFIDWrite",    int'(bus.IFIDWrite),    int'(e.ifid));
        chk("IFIDFlush",    int'(bus.IFIDFlush),    int'(e.flush));
        chk("IDEXBubble",   int'(bus.IDEXBubble),   int'(e.bubble));
        chk("PipeHold",     int'(bus.PipeHold),     int'(e.hold));
        chk("State",        int'(bus.State),        int'(e.st));
        chk("StallTimeout", int'(bus.StallTimeout), int'(e.tmo));
        chk("StallCycles",  int'(bus.StallCycles),  e.sc);
        chk("FlushCount",   int'(bus.FlushCount),   e.fc);
      end
    end
  end

  initial begin
    rst             = 1'b1;
    bus.StallReq    = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.JumpTaken   = 1'b0;
    bus.MemBusy     = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();

    // Reset state and first release
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Single hazard stall
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Branch while memory busy for 3 cycles, flush on the 4th
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Timeout after MAX_STALL consecutive stalls, sticky until reset
    repeat (MAX_STALL) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // One short of the limit, then a frozen cycle, then one more stall
    repeat (MAX_STALL - 1) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Branch masked by a hazard stall
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Branch and jump together: a single flush
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0);

    // Pending flush survives a stall, then is applied
    drive(0, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Reset discards a pending flush
    drive(0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99, 0) < 2,
            $urandom_range(99, 0) < 25,
            $urandom_range(99, 0) < 15,
            $urandom_range(99, 0) < 10,
            $urandom_range(99, 0) < 20);
    end

`ifdef STALL_COUNTERS_EN
    // Stall counter saturation
    drive(1, 0, 0, 0, 0);
    repeat (SAT + 1) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
`endif

    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter MAX_STALL, default 4, meaning consecutive hazard-stall cycles that set StallTimeout (legal 2..7).
REQ-002 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port Rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port StallReq, input, 1, load-use/branch-operand hazard stall request from the hazard detection unit.
REQ-005 SHALL have port BranchTaken, input, 1, branch resolved taken in decode.
REQ-006 SHALL have port JumpTaken, input, 1, jump resolved in decode.
REQ-007 SHALL have port MemBusy, input, 1, data memory not ready; the whole pipeline must freeze.
REQ-008 SHALL have port PCWrite, output, 1, PC register write enable.
REQ-009 SHALL have port IFIDWrite, output, 1, IF/ID register write enable.
REQ-010 SHALL have port IFIDFlush, output, 1, clear IF/ID to NOP.
REQ-011 SHALL have port IDEXBubble, output, 1, zero ID/EX control signals.
REQ-012 SHALL have port PipeHold, output, 1, freeze ID/EX, EX/MEM, MEM/WB.
REQ-013 SHALL have port State, output, 2, current state (00 RUN, 01 STALL, 10 MEMWAIT).
REQ-014 SHALL have port StallTimeout, output, 1, sticky error flag.
REQ-015 SHALL have ports StallCycles and FlushCount, output, 16 each, performance counters.

Function
REQ-016 Control outputs SHALL be combinational from current inputs and registered state, effective in the same cycle, with priority Rst > MemBusy > StallReq > flush > normal.
REQ-017 With MemBusy=1: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=0, PipeHold=1.
REQ-018 With MemBusy=0, StallReq=1: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0, PipeHold=0; BranchTaken/JumpTaken SHALL be ignored (branch unresolved).
REQ-019 With MemBusy=0, StallReq=0 and (BranchTaken|JumpTaken|PendingFlush): PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXBubble=0, PipeHold=0.
REQ-020 Otherwise: PCWrite=1, IFIDWrite=1, all other controls 0.
REQ-021 Next state SHALL be MEMWAIT if MemBusy, else STALL if StallReq, else RUN.
REQ-022 Internal PendingFlush SHALL set when (BranchTaken|JumpTaken) and MemBusy=1, hold through MemBusy/StallReq cycles, and clear in the cycle the flush of REQ-019 is applied.
REQ-023 Internal 3-bit StallRun SHALL increment in each REQ-018 cycle, hold during MemBusy cycles, clear in REQ-019/020 cycles.
REQ-024 StallTimeout SHALL set when a REQ-018 cycle occurs with StallRun==MAX_STALL-1, and remain 1 until Rst.
REQ-025 Simultaneous BranchTaken and JumpTaken SHALL produce a single flush, counted once.

Reset
REQ-026 While Rst=1: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, PipeHold=0.
REQ-027 On a clock edge with Rst=1: State=RUN, PendingFlush=0, StallRun=0, StallTimeout=0, StallCycles=0, FlushCount=0; reset mid-stall or mid-MEMWAIT discards any pending flush.

Configuration
REQ-028 Macro STALL_COUNTERS_EN defined: StallCycles SHALL increment per REQ-018 cycle and FlushCount per REQ-019 cycle, both saturating at 16'hFFFF.
REQ-029 Macro STALL_COUNTERS_EN undefined: counter logic SHALL be absent, ports remain and read constant 0.

Verification
REQ-030 Single hazard: StallReq=1 for 1 cycle -> that cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1; next cycle State=01, PCWrite=1; StallCycles=1.
REQ-031 Branch during MemBusy: BranchTaken=1 with MemBusy=1, MemBusy held 3 cycles -> PipeHold=1 for 3 cycles, IFIDFlush=1 exactly in the 4th cycle, FlushCount=1.
REQ-032 Timeout: MAX_STALL=4, StallReq held 4 cycles -> StallTimeout=1 after 4th edge, stays 1 after StallReq drops, clears only on Rst.
REQ-033 Masked branch: StallReq=1 and BranchTaken=1 together -> IFIDFlush=0, IDEXBubble=1, FlushCount unchanged.
REQ-034 Reset mid-operation: pending flush set, then Rst=1 one cycle -> State=00, counters 0, no IFIDFlush after Rst drops.
REQ-035 Saturation (counters enabled): StallCycles preloaded to 16'hFFFF via 65535 stall cycles, one more stall -> stays 16'hFFFF.
